// File: rtl/serial_parity_checker.sv
`default_nettype none
// ============================================================================
// Module   : serial_parity_checker
// Purpose  : Bit-serial frame receiver: DATA_BITS data bits (LSB first) plus
//            one parity bit, with parity check, word output and done pulse.
//            Define PARITY_ERR_COUNT_EN to build the saturating error counter.
// Revision : 1.0
// ============================================================================
module serial_parity_checker #(
  parameter int DATA_BITS = 8,
  parameter bit ODD       = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic                 busy,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_ok,
  output logic                 done,
  output logic [7:0]           err_count
);

  localparam int c_CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   r_data_out;
  logic [c_CNT_W-1:0]     r_cnt;
  logic                   r_acc;
  logic                   r_parity_ok;
  logic                   w_last_bit;
  logic                   w_ok;

  assign w_last_bit = (r_cnt == c_LAST);
  assign w_ok       = ((r_acc ^ bit_in) == ODD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_DATA;
      S_DATA:   if (bit_valid && w_last_bit) w_state_nxt = S_PARITY;
      S_PARITY: if (bit_valid) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // First bit received walks down to bit 0 after DATA_BITS shifts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift     <= '0;
      r_acc       <= 1'b0;
      r_cnt       <= '0;
      r_data_out  <= '0;
      r_parity_ok <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc <= 1'b0;
            r_cnt <= '0;
          end
        end
        S_DATA: begin
          if (bit_valid) begin
            r_acc   <= r_acc ^ bit_in;
            r_shift <= {bit_in, r_shift[DATA_BITS-1:1]};
            r_cnt   <= r_cnt + c_CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (bit_valid) begin
            r_data_out  <= r_shift;
            r_parity_ok <= w_ok;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PARITY_ERR_COUNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_count <= 8'h00;
    end else if ((r_state == S_PARITY) && bit_valid && !w_ok && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = 8'h00;
`endif

  assign busy      = (r_state == S_DATA) || (r_state == S_PARITY);
  assign done      = (r_state == S_DONE);
  assign data_out  = r_data_out;
  assign parity_ok = r_parity_ok;

endmodule
`default_nettype wire
